// File: rtl/preg_reclaim_pkg.sv
// Shared rename definitions: physical register index width, index type and the
// hardwired-zero mapping that is never returned to a free list.
package preg_reclaim_pkg;
    localparam int PREG_W = 6;
    typedef logic [PREG_W-1:0] preg_t;
    localparam preg_t PREG_ZERO = '0;
endpackage

// File: rtl/preg_reclaim_queue.sv
// Per-parity staging FIFO: two ordered write ports (slot 0 before slot 1) and a
// single read port that pops the head when the free list accepts it.
module reclaim_queue
    import preg_reclaim_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = PREG_W
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic          i_wr0_en,
    input  logic [PW-1:0] i_wr0_data,
    input  logic          i_wr1_en,
    input  logic [PW-1:0] i_wr1_data,
    input  logic          i_rd_en,
    output logic          o_free_ge2,
    output logic          o_empty,
    output logic [PW-1:0] o_head
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PTRW = AW + 1;

    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic [PTRW-1:0] occ;
    logic [PW-1:0]   mem [DEPTH];
    logic [PW-1:0]   first_data;
    logic [AW-1:0]   slot_a;
    logic [AW-1:0]   slot_b;
    logic [1:0]      n_push;

    // A lone slot-1 write lands at the tail, so the first live write is compacted.
    always_comb begin
        first_data = i_wr0_en ? i_wr0_data : i_wr1_data;
        slot_a     = tail[AW-1:0];
        slot_b     = slot_a + AW'(1);
        n_push     = {1'b0, i_wr0_en} + {1'b0, i_wr1_en};
    end

    always_ff @(posedge i_clk) begin
        if (i_wr0_en | i_wr1_en)
            mem[slot_a] <= first_data;
        if (i_wr0_en & i_wr1_en)
            mem[slot_b] <= i_wr1_data;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            head <= '0;
            tail <= '0;
        end else begin
            tail <= tail + PTRW'(n_push);
            head <= head + PTRW'(i_rd_en);
        end
    end

    // Wrap-bit pointers make the modular difference the exact occupancy.
    assign occ        = tail - head;
    assign o_empty    = (head == tail);
    assign o_free_ge2 = (occ <= PTRW'(DEPTH - 2));
    assign o_head     = mem[head[AW-1:0]];
endmodule

// File: rtl/preg_reclaim.sv
// Commit-side return path: steers two freed indices per cycle by parity into
// staging queues and drains each into its free list one write per cycle.
module preg_reclaim
    import preg_reclaim_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = PREG_W
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic [1:0]    i_ret_valid,
    input  logic [PW-1:0] i_ret_preg0,
    input  logic [PW-1:0] i_ret_preg1,
    output logic          o_ret_ready,
    output logic          o_even_wr_en,
    output logic [PW-1:0] o_even_wr_data,
    input  logic          i_even_full,
    output logic          o_odd_wr_en,
    output logic [PW-1:0] o_odd_wr_data,
    input  logic          i_odd_full,
    output logic          o_idle
);
    logic even_ge2, odd_ge2, even_empty, odd_empty;
    logic take0, take1;
    logic even_wr0, even_wr1, odd_wr0, odd_wr1;

    // Accepted slots carrying the zero mapping are dropped before steering.
    always_comb begin
        take0    = i_ret_valid[0] & o_ret_ready & (i_ret_preg0 != PW'(PREG_ZERO));
        take1    = i_ret_valid[1] & o_ret_ready & (i_ret_preg1 != PW'(PREG_ZERO));
        even_wr0 = take0 & ~i_ret_preg0[0];
        odd_wr0  = take0 &  i_ret_preg0[0];
        even_wr1 = take1 & ~i_ret_preg1[0];
        odd_wr1  = take1 &  i_ret_preg1[0];
    end

    assign o_ret_ready  = i_resetn & even_ge2 & odd_ge2;
    assign o_even_wr_en = ~even_empty & ~i_even_full;
    assign o_odd_wr_en  = ~odd_empty & ~i_odd_full;
    assign o_idle       = even_empty & odd_empty;

    reclaim_queue #(.DEPTH(DEPTH), .PW(PW)) u_even (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_wr0_en   (even_wr0),
        .i_wr0_data (i_ret_preg0),
        .i_wr1_en   (even_wr1),
        .i_wr1_data (i_ret_preg1),
        .i_rd_en    (o_even_wr_en),
        .o_free_ge2 (even_ge2),
        .o_empty    (even_empty),
        .o_head     (o_even_wr_data)
    );

    reclaim_queue #(.DEPTH(DEPTH), .PW(PW)) u_odd (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_wr0_en   (odd_wr0),
        .i_wr0_data (i_ret_preg0),
        .i_wr1_en   (odd_wr1),
        .i_wr1_data (i_ret_preg1),
        .i_rd_en    (o_odd_wr_en),
        .o_free_ge2 (odd_ge2),
        .o_empty    (odd_empty),
        .o_head     (o_odd_wr_data)
    );
endmodule

// File: tb/tb_preg_reclaim.sv
// Self-checking bench for preg_reclaim: directed scenarios plus randomized
// traffic against a queue-based model of the parity staging behaviour.
module tb_preg_reclaim;
    localparam int DEPTH = 4;
    localparam int PW    = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    ret_valid;
    logic [PW-1:0] ret_preg0, ret_preg1;
    logic          ret_ready;
    logic          even_wr_en, odd_wr_en;
    logic [PW-1:0] even_wr_data, odd_wr_data;
    logic          even_full, odd_full;
    logic          idle;

    int checks   = 0;
    int failures = 0;

    int eq[$];
    int oq[$];

    always #5 clk = ~clk;

    preg_reclaim #(.DEPTH(DEPTH), .PW(PW)) dut (
        .i_clk          (clk),
        .i_resetn       (rst_n),
        .i_ret_valid    (ret_valid),
        .i_ret_preg0    (ret_preg0),
        .i_ret_preg1    (ret_preg1),
        .o_ret_ready    (ret_ready),
        .o_even_wr_en   (even_wr_en),
        .o_even_wr_data (even_wr_data),
        .i_even_full    (even_full),
        .o_odd_wr_en    (odd_wr_en),
        .o_odd_wr_data  (odd_wr_data),
        .i_odd_full     (odd_full),
        .o_idle         (idle)
    );

    function automatic bit model_ready();
        return rst_n && (eq.size() <= DEPTH - 2) && (oq.size() <= DEPTH - 2);
    endfunction

    task automatic set_in(input logic [1:0] v, input int p0, input int p1,
                          input logic ef, input logic of);
        ret_valid = v;
        ret_preg0 = PW'(p0);
        ret_preg1 = PW'(p1);
        even_full = ef;
        odd_full  = of;
    endtask

    // Model step at the rising edge: drain heads that the free lists take,
    // then append accepted non-zero indices in slot order by parity.
    task automatic advance();
        bit acc;
        bit pop_e, pop_o;
        acc   = model_ready();
        pop_e = (eq.size() > 0) && !even_full;
        pop_o = (oq.size() > 0) && !odd_full;
        @(posedge clk);
        if (pop_e) void'(eq.pop_front());
        if (pop_o) void'(oq.pop_front());
        if (acc) begin
            if (ret_valid[0] && ret_preg0 != 0) begin
                if (ret_preg0[0]) oq.push_back(int'(ret_preg0)); else eq.push_back(int'(ret_preg0));
            end
            if (ret_valid[1] && ret_preg1 != 0) begin
                if (ret_preg1[0]) oq.push_back(int'(ret_preg1)); else eq.push_back(int'(ret_preg1));
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(2'b11, 2, 3, 1'b0, 1'b0);
        #3;
        checks++; if (ret_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", ret_ready); end
        checks++; if (even_wr_en !== 1'b0 || odd_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en got=%b%b exp=00", even_wr_en, odd_wr_en); end
        checks++; if (idle !== 1'b1) begin failures++; $display("[TB] FAIL reset_idle got=%b exp=1", idle); end
        @(posedge clk); #1;
        set_in(2'b00, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (ret_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%b exp=1", ret_ready); end
        advance();
    endtask

    task automatic test_single_return();
        set_in(2'b01, 34, 0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ret_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_ready got=%b exp=1", ret_ready); end
        advance();
        set_in(2'b00, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (even_wr_en !== 1'b1 || even_wr_data !== PW'(34)) begin failures++; $display("[TB] FAIL single_even got en=%b data=%0d exp en=1 data=34", even_wr_en, even_wr_data); end
        checks++; if (odd_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL single_odd_en got=%b exp=0", odd_wr_en); end
        advance();
        @(negedge clk);
        checks++; if (idle !== 1'b1 || even_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL single_idle got idle=%b en=%b exp idle=1 en=0", idle, even_wr_en); end
        advance();
    endtask

    task automatic test_mixed_pair();
        set_in(2'b11, 40, 41, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (even_wr_en !== 1'b0 || odd_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL mixed_no_bypass got=%b%b exp=00", even_wr_en, odd_wr_en); end
        advance();
        set_in(2'b00, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (even_wr_en !== 1'b1 || even_wr_data !== PW'(40)) begin failures++; $display("[TB] FAIL mixed_even got en=%b data=%0d exp en=1 data=40", even_wr_en, even_wr_data); end
        checks++; if (odd_wr_en !== 1'b1 || odd_wr_data !== PW'(41)) begin failures++; $display("[TB] FAIL mixed_odd got en=%b data=%0d exp en=1 data=41", odd_wr_en, odd_wr_data); end
        advance();
    endtask

    task automatic test_same_parity();
        int exp_data[3] = '{50, 52, 54};
        set_in(2'b11, 50, 52, 1'b0, 1'b0);
        @(negedge clk);
        advance();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_in(2'b01, 54, 0, 1'b0, 1'b0);
            else        set_in(2'b00, 0, 0, 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (even_wr_en !== 1'b1 || even_wr_data !== PW'(exp_data[i])) begin failures++; $display("[TB] FAIL same_order[%0d] got en=%b data=%0d exp en=1 data=%0d", i, even_wr_en, even_wr_data, exp_data[i]); end
            checks++; if (ret_ready !== 1'b1) begin failures++; $display("[TB] FAIL same_ready[%0d] got=%b exp=1", i, ret_ready); end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int exp_data[4]  = '{44, 46, 48, 60};
        bit exp_ready[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        set_in(2'b10, 0, 39, 1'b1, 1'b0);
        @(negedge clk);
        advance();
        set_in(2'b11, 44, 46, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (odd_wr_en !== 1'b1 || odd_wr_data !== PW'(39)) begin failures++; $display("[TB] FAIL bp_odd_drain got en=%b data=%0d exp en=1 data=39", odd_wr_en, odd_wr_data); end
        checks++; if (even_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL bp_even_stall got=%b exp=0", even_wr_en); end
        advance();
        set_in(2'b11, 48, 60, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (ret_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_occ2 got=%b exp=1", ret_ready); end
        advance();
        set_in(2'b11, 35, 37, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (ret_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_full got=%b exp=0", ret_ready); end
        advance();
        for (int i = 0; i < 4; i++) begin
            set_in(2'b00, 0, 0, 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (even_wr_en !== 1'b1 || even_wr_data !== PW'(exp_data[i])) begin failures++; $display("[TB] FAIL bp_drain[%0d] got en=%b data=%0d exp en=1 data=%0d", i, even_wr_en, even_wr_data, exp_data[i]); end
            checks++; if (ret_ready !== exp_ready[i]) begin failures++; $display("[TB] FAIL bp_ready[%0d] got=%b exp=%b", i, ret_ready, exp_ready[i]); end
            checks++; if (odd_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL bp_odd_rejected[%0d] got=%b exp=0", i, odd_wr_en); end
            advance();
        end
    endtask

    task automatic test_zero_discard();
        set_in(2'b11, 0, 33, 1'b0, 1'b0);
        @(negedge clk);
        advance();
        set_in(2'b00, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (odd_wr_en !== 1'b1 || odd_wr_data !== PW'(33)) begin failures++; $display("[TB] FAIL zero_odd got en=%b data=%0d exp en=1 data=33", odd_wr_en, odd_wr_data); end
        checks++; if (even_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL zero_even got=%b exp=0", even_wr_en); end
        advance();
        @(negedge clk);
        checks++; if (idle !== 1'b1) begin failures++; $display("[TB] FAIL zero_idle got=%b exp=1", idle); end
        advance();
    endtask

    task automatic test_async_reset();
        set_in(2'b11, 2, 4, 1'b1, 1'b1);
        @(negedge clk);
        advance();
        set_in(2'b01, 7, 0, 1'b1, 1'b1);
        @(negedge clk);
        advance();
        set_in(2'b00, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (even_wr_en !== 1'b1 || odd_wr_en !== 1'b1 || idle !== 1'b0) begin failures++; $display("[TB] FAIL areset_staged got en=%b%b idle=%b exp en=11 idle=0", even_wr_en, odd_wr_en, idle); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (even_wr_en !== 1'b0 || odd_wr_en !== 1'b0 || idle !== 1'b1 || ret_ready !== 1'b0) begin failures++; $display("[TB] FAIL areset_immediate got en=%b%b idle=%b ready=%b exp en=00 idle=1 ready=0", even_wr_en, odd_wr_en, idle, ret_ready); end
        eq.delete();
        oq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (even_wr_en !== 1'b0 || odd_wr_en !== 1'b0 || idle !== 1'b1 || ret_ready !== 1'b1) begin failures++; $display("[TB] FAIL areset_after[%0d] got en=%b%b idle=%b ready=%b exp en=00 idle=1 ready=1", i, even_wr_en, odd_wr_en, idle, ret_ready); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(2'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63)),
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            @(negedge clk);
            checks++; if (ret_ready !== model_ready()) begin failures++; $display("[TB] FAIL rand_ready cyc=%0d got=%b exp=%b", n, ret_ready, model_ready()); end
            checks++; if (even_wr_en !== (eq.size() > 0 && !even_full)) begin failures++; $display("[TB] FAIL rand_even_en cyc=%0d got=%b exp=%b", n, even_wr_en, (eq.size() > 0 && !even_full)); end
            if (eq.size() > 0 && !even_full) begin
                checks++; if (even_wr_data !== PW'(eq[0])) begin failures++; $display("[TB] FAIL rand_even_data cyc=%0d got=%0d exp=%0d", n, even_wr_data, eq[0]); end
            end
            checks++; if (odd_wr_en !== (oq.size() > 0 && !odd_full)) begin failures++; $display("[TB] FAIL rand_odd_en cyc=%0d got=%b exp=%b", n, odd_wr_en, (oq.size() > 0 && !odd_full)); end
            if (oq.size() > 0 && !odd_full) begin
                checks++; if (odd_wr_data !== PW'(oq[0])) begin failures++; $display("[TB] FAIL rand_odd_data cyc=%0d got=%0d exp=%0d", n, odd_wr_data, oq[0]); end
            end
            checks++; if (idle !== (eq.size() == 0 && oq.size() == 0)) begin failures++; $display("[TB] FAIL rand_idle cyc=%0d got=%b exp=%b", n, idle, (eq.size() == 0 && oq.size() == 0)); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single_return();
        test_mixed_pair();
        test_same_parity();
        test_backpressure();
        test_zero_discard();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
